sensor_qualifier: RTL and testbench

- Upstream front end of the alarm stage.
- Synchronises and debounces the raw sensor and switch pins (gases, movimiento, clave, sw_on).
- Qualifies persistent gas and movement detections and runs the arm/disarm state machine.
- Presents clean, latched alarm requests (gas_alarm, mov_alarm, alarm_req) that the downstream alarm stage turns into sound, mensaje and the LED blink.

---
 rtl/sensor_qualifier_pkg.sv | 17 +
 rtl/sensor_debounce.sv | 43 ++++
 rtl/sensor_qualifier.sv | 153 +++++++++++++++
 tb/tb_sensor_qualifier.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_qualifier_pkg.sv
// Shared state encoding and default timing constants for the alarm front end.
package sensor_qualifier_pkg;

    localparam int unsigned      DEF_CNT_W          = 27;
    localparam logic [26:0]      DEF_DEB_CYCLES     = 27'd500000;
    localparam logic [26:0]      DEF_LIM_GASES      = 27'd100000000;
    localparam logic [26:0]      DEF_LIM_MOVIMIENTO = 27'd100000000;
    localparam logic [26:0]      DEF_ARM_DELAY      = 27'd100000000;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        ARMED    = 2'd2,
        ALARM    = 2'd3
    } state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stability counter: the output takes a new
// level only after the synchronised input has disagreed with it for DEB_CYCLES cycles.
module sensor_debounce #(
    parameter int unsigned      CNT_W      = 27,
    parameter logic [CNT_W-1:0] DEB_CYCLES = 27'd500000,
    parameter logic             RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_db
);

    localparam logic [CNT_W-1:0] DEB_LAST = DEB_CYCLES - CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= RST_VAL;
            r_cnt <= '0;
        end else begin
            r_s1 <= i_pin;
            r_s2 <= r_s1;
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_LAST) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_db = r_db;

endmodule

// File: rtl/sensor_qualifier.sv
// Alarm front end: debounces the four raw pins, qualifies persistent gas and
// motion, and runs the arm/disarm state machine with latched alarm requests.
module sensor_qualifier
    import sensor_qualifier_pkg::*;
#(
    parameter int unsigned      CNT_W          = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEB_CYCLES     = DEF_DEB_CYCLES,
    parameter logic [CNT_W-1:0] LIM_GASES      = DEF_LIM_GASES,
    parameter logic [CNT_W-1:0] LIM_MOVIMIENTO = DEF_LIM_MOVIMIENTO,
    parameter logic [CNT_W-1:0] ARM_DELAY      = DEF_ARM_DELAY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_on,
    input  logic gases,
    input  logic movimiento,
    input  logic clave,
    output logic armed,
    output logic arming,
    output logic gas_alarm,
    output logic mov_alarm,
    output logic alarm_req,
    output logic event_pulse
);

    localparam logic [CNT_W-1:0] GAS_LAST = LIM_GASES - CNT_W'(1);
    localparam logic [CNT_W-1:0] MOV_LAST = LIM_MOVIMIENTO - CNT_W'(1);
    localparam logic [CNT_W-1:0] ARM_LAST = ARM_DELAY - CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_gas_cnt;
    logic [CNT_W-1:0] r_mov_cnt;
    logic [CNT_W-1:0] r_arm_cnt;
    logic             r_gas_alarm;
    logic             r_mov_alarm;
    logic             r_alarm_req;
    logic             r_event;
    logic             r_clave_db_d;

    logic w_sw_db;
    logic w_gas_db;
    logic w_mov_db;
    logic w_clave_db;
    logic w_clave_edge;
    logic w_disarm;
    logic w_gas_set;
    logic w_gas_clr;
    logic w_mov_set;

    // The switch is active-low, so its debounced level idles high (disarmed).
    sensor_debounce #(.CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b1)) u_db_sw (
        .clk(clk), .rst_n(rst_n), .i_pin(sw_on), .o_db(w_sw_db)
    );
    sensor_debounce #(.CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_db_gas (
        .clk(clk), .rst_n(rst_n), .i_pin(gases), .o_db(w_gas_db)
    );
    sensor_debounce #(.CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_db_mov (
        .clk(clk), .rst_n(rst_n), .i_pin(movimiento), .o_db(w_mov_db)
    );
    sensor_debounce #(.CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES), .RST_VAL(1'b0)) u_db_clave (
        .clk(clk), .rst_n(rst_n), .i_pin(clave), .o_db(w_clave_db)
    );

    assign w_clave_edge = w_clave_db & ~r_clave_db_d;
    assign w_disarm     = w_sw_db | w_clave_edge;
    assign w_gas_set    = w_gas_db && (r_gas_cnt == GAS_LAST);
    assign w_gas_clr    = w_clave_edge && !w_gas_db;
    // A disarm request in the same cycle suppresses motion qualification.
    assign w_mov_set    = (r_state == ARMED) && w_mov_db && (r_mov_cnt == MOV_LAST) && !w_disarm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clave_db_d <= 1'b0;
            r_gas_cnt    <= '0;
            r_mov_cnt    <= '0;
            r_gas_alarm  <= 1'b0;
            r_alarm_req  <= 1'b0;
            r_event      <= 1'b0;
        end else begin
            r_clave_db_d <= w_clave_db;

            if (!w_gas_db)
                r_gas_cnt <= '0;
            else if (r_gas_cnt != GAS_LAST)
                r_gas_cnt <= r_gas_cnt + CNT_W'(1);

            if ((r_state == ARMED) && w_mov_db) begin
                if (r_mov_cnt != MOV_LAST)
                    r_mov_cnt <= r_mov_cnt + CNT_W'(1);
            end else begin
                r_mov_cnt <= '0;
            end

            if (w_gas_set)
                r_gas_alarm <= 1'b1;
            else if (w_gas_clr)
                r_gas_alarm <= 1'b0;

            r_alarm_req <= r_gas_alarm | r_mov_alarm;
            r_event     <= (w_gas_set & ~r_gas_alarm) | (w_mov_set & ~r_mov_alarm);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= DISARMED;
            r_arm_cnt   <= '0;
            r_mov_alarm <= 1'b0;
        end else begin
            case (r_state)
                DISARMED: begin
                    if (!w_sw_db) begin
                        r_state   <= ARMING;
                        r_arm_cnt <= '0;
                    end
                end
                ARMING: begin
                    if (w_disarm)
                        r_state <= DISARMED;
                    else if (r_arm_cnt == ARM_LAST)
                        r_state <= ARMED;
                    else
                        r_arm_cnt <= r_arm_cnt + CNT_W'(1);
                end
                ARMED: begin
                    if (w_disarm) begin
                        r_state     <= DISARMED;
                        r_mov_alarm <= 1'b0;
                    end else if (w_mov_set) begin
                        r_state     <= ALARM;
                        r_mov_alarm <= 1'b1;
                    end
                end
                ALARM: begin
                    // Only a valid code ends an intrusion; the switch alone cannot.
                    if (w_clave_edge) begin
                        r_state     <= DISARMED;
                        r_mov_alarm <= 1'b0;
                    end
                end
                default: r_state <= DISARMED;
            endcase
        end
    end

    assign armed       = (r_state == ARMED) || (r_state == ALARM);
    assign arming      = (r_state == ARMING);
    assign gas_alarm   = r_gas_alarm;
    assign mov_alarm   = r_mov_alarm;
    assign alarm_req   = r_alarm_req;
    assign event_pulse = r_event;

endmodule

// File: tb/tb_sensor_qualifier.sv
// Directed vector table, reset corner cases and random stimulus for sensor_qualifier,
// all cross-checked every cycle against a run-length based reference model.
module tb_sensor_qualifier;

    localparam int DEB = 4;
    localparam int LG  = 20;
    localparam int LM  = 10;
    localparam int AD  = 30;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw_on = 1'b1;
    logic gases = 1'b0;
    logic movimiento = 1'b0;
    logic clave = 1'b0;
    logic armed, arming, gas_alarm, mov_alarm, alarm_req, event_pulse;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    sensor_qualifier #(
        .CNT_W(27),
        .DEB_CYCLES(27'd4),
        .LIM_GASES(27'd20),
        .LIM_MOVIMIENTO(27'd10),
        .ARM_DELAY(27'd30)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw_on(sw_on), .gases(gases),
        .movimiento(movimiento), .clave(clave), .armed(armed), .arming(arming),
        .gas_alarm(gas_alarm), .mov_alarm(mov_alarm), .alarm_req(alarm_req),
        .event_pulse(event_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: pins are 0 sw, 1 gas, 2 mov, 3 clave.
    typedef enum {M_OFF, M_EXIT, M_ON, M_INTR} mode_t;
    logic [1:0] m_dl [4];
    logic [3:0] m_run_val;
    int         m_run_len [4];
    logic [3:0] m_db;
    logic       m_clave_prev, m_gas, m_mov, m_req, m_evt;
    int         m_gas_run, m_mov_run, m_exit_t;
    mode_t      m_mode;

    function automatic logic [5:0] dut_vec();
        return {armed, arming, gas_alarm, mov_alarm, alarm_req, event_pulse};
    endfunction

    function automatic logic [5:0] model_vec();
        return {(m_mode == M_ON) || (m_mode == M_INTR), m_mode == M_EXIT, m_gas, m_mov, m_req, m_evt};
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 4; p++) begin
            m_dl[p] = 2'b00;
            m_run_len[p] = 0;
        end
        m_run_val = 4'b0000;
        m_db = 4'b0001;
        m_clave_prev = 1'b0;
        {m_gas, m_mov, m_req, m_evt} = 4'b0000;
        m_gas_run = 0;
        m_mov_run = 0;
        m_exit_t = 0;
        m_mode = M_OFF;
    endtask

    task automatic model_step();
        logic [3:0] raw;
        logic [3:0] db_o;
        logic       edge_c, gas_n, mov_n, v;
        mode_t      mode_n;
        raw = {clave, movimiento, gases, sw_on};
        db_o = m_db;
        edge_c = db_o[3] & ~m_clave_prev;
        gas_n = m_gas;
        if (db_o[1] && m_gas_run >= LG - 1) gas_n = 1'b1;
        else if (edge_c && !db_o[1]) gas_n = 1'b0;
        mov_n = m_mov;
        mode_n = m_mode;
        case (m_mode)
            M_OFF: if (!db_o[0]) begin mode_n = M_EXIT; m_exit_t = 0; end
            M_EXIT: begin
                if (db_o[0] || edge_c) mode_n = M_OFF;
                else if (m_exit_t == AD - 1) mode_n = M_ON;
                else m_exit_t++;
            end
            M_ON: begin
                if (db_o[0] || edge_c) begin mode_n = M_OFF; mov_n = 1'b0; end
                else if (db_o[2] && m_mov_run >= LM - 1) begin mode_n = M_INTR; mov_n = 1'b1; end
            end
            default: if (edge_c) begin mode_n = M_OFF; mov_n = 1'b0; end
        endcase
        m_gas_run = db_o[1] ? ((m_gas_run < LG - 1) ? m_gas_run + 1 : m_gas_run) : 0;
        m_mov_run = (m_mode == M_ON && db_o[2]) ? ((m_mov_run < LM - 1) ? m_mov_run + 1 : m_mov_run) : 0;
        m_req = m_gas | m_mov;
        m_evt = (gas_n & ~m_gas) | (mov_n & ~m_mov);
        m_gas = gas_n;
        m_mov = mov_n;
        m_mode = mode_n;
        m_clave_prev = db_o[3];
        // A debounced level follows the synchronised pin once it has held a new value DEB times running.
        for (int p = 0; p < 4; p++) begin
            v = m_dl[p][1];
            m_dl[p] = {m_dl[p][0], raw[p]};
            if (v == m_run_val[p]) m_run_len[p]++;
            else begin m_run_val[p] = v; m_run_len[p] = 1; end
            if (m_run_val[p] != m_db[p] && m_run_len[p] >= DEB) m_db[p] = m_run_val[p];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL model cyc=%0d got=%b want=%b (armed,arming,gas,mov,req,evt)",
                     cyc, dut_vec(), model_vec());
        end
    endtask

    typedef struct {
        logic        sw, g, m, c;
        int unsigned n;
        logic [5:0]  exp;
        string       name;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic sw, logic g, logic m, logic c, int unsigned n,
                                logic [5:0] e, string name);
        vec_t r;
        r.sw = sw; r.g = g; r.m = m; r.c = c; r.n = n; r.exp = e; r.name = name;
        return r;
    endfunction

    int lat;

    initial begin
        // expected bits: armed, arming, gas_alarm, mov_alarm, alarm_req, event_pulse
        vq.push_back(mk(1, 0, 0, 0, 10, 6'b000000, "idle"));
        vq.push_back(mk(1, 1, 0, 0,  3, 6'b000000, "glitch3"));
        vq.push_back(mk(1, 0, 0, 0, 10, 6'b000000, "glitch_after"));
        vq.push_back(mk(1, 1, 0, 0, 25, 6'b000000, "gas_pre25"));
        vq.push_back(mk(1, 1, 0, 0,  1, 6'b001001, "gas_set26"));
        vq.push_back(mk(1, 1, 0, 0,  1, 6'b001010, "gas_req"));
        vq.push_back(mk(1, 1, 0, 1,  8, 6'b001010, "gas_clave_blocked"));
        vq.push_back(mk(1, 1, 0, 0,  8, 6'b001010, "gas_clave_rel"));
        vq.push_back(mk(1, 0, 0, 0,  8, 6'b001010, "gas_drop_latched"));
        vq.push_back(mk(1, 0, 0, 1,  6, 6'b001010, "gas_clave_pre"));
        vq.push_back(mk(1, 0, 0, 1,  1, 6'b000010, "gas_cleared"));
        vq.push_back(mk(1, 0, 0, 1,  1, 6'b000000, "req_cleared"));
        vq.push_back(mk(1, 0, 0, 0,  8, 6'b000000, "clave_rel"));
        vq.push_back(mk(0, 0, 0, 0,  7, 6'b010000, "arming_on"));
        vq.push_back(mk(0, 0, 0, 0, 10, 6'b010000, "arming_mid"));
        vq.push_back(mk(1, 0, 0, 0,  6, 6'b010000, "abort_pre"));
        vq.push_back(mk(1, 0, 0, 0,  1, 6'b000000, "abort_done"));
        vq.push_back(mk(0, 0, 0, 0,  7, 6'b010000, "arm2_on"));
        vq.push_back(mk(0, 0, 0, 0, 29, 6'b010000, "arm2_pre"));
        vq.push_back(mk(0, 0, 0, 0,  1, 6'b100000, "armed"));
        vq.push_back(mk(0, 0, 1, 0, 15, 6'b100000, "mov_pre"));
        vq.push_back(mk(0, 0, 1, 0,  1, 6'b100101, "mov_set"));
        vq.push_back(mk(0, 0, 1, 0,  1, 6'b100110, "mov_req"));
        vq.push_back(mk(0, 0, 0, 0, 10, 6'b100110, "alarm_hold"));
        vq.push_back(mk(1, 0, 0, 0, 10, 6'b100110, "sw_no_silence"));
        vq.push_back(mk(1, 0, 0, 1,  6, 6'b100110, "alarm_clave_pre"));
        vq.push_back(mk(1, 0, 0, 1,  1, 6'b000010, "alarm_disarm"));
        vq.push_back(mk(1, 0, 0, 1,  1, 6'b000000, "alarm_req_off"));
        vq.push_back(mk(1, 0, 0, 0,  8, 6'b000000, "clave_rel2"));
        vq.push_back(mk(0, 0, 0, 0, 37, 6'b100000, "arm3"));
        vq.push_back(mk(0, 0, 1, 0,  9, 6'b100000, "coll_mov"));
        vq.push_back(mk(0, 0, 1, 1,  6, 6'b100000, "coll_pre"));
        vq.push_back(mk(0, 0, 1, 1,  1, 6'b000000, "coll_disarm_wins"));
        vq.push_back(mk(1, 0, 0, 0, 10, 6'b000000, "coll_after"));
        vq.push_back(mk(0, 1, 0, 0, 37, 6'b101010, "gas_and_armed"));
        vq.push_back(mk(0, 1, 1, 0, 16, 6'b101111, "alarm_with_gas"));

        model_reset();
        #1;
        total++;
        if (dut_vec() !== 6'b000000) begin
            bad++;
            $display("FAIL reset_state got=%b want=000000", dut_vec());
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            sw_on = vq[i].sw; gases = vq[i].g; movimiento = vq[i].m; clave = vq[i].c;
            for (int unsigned k = 0; k < vq[i].n; k++) cycle();
            total++;
            if (dut_vec() !== vq[i].exp) begin
                bad++;
                $display("FAIL vec %0d %s got=%b want=%b", i, vq[i].name, dut_vec(), vq[i].exp);
            end
        end

        // Asynchronous reset in ALARM with gas latched, sensors left asserted.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (dut_vec() !== 6'b000000) begin
            bad++;
            $display("FAIL async_reset got=%b want=000000", dut_vec());
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if (dut_vec() !== 6'b000000) begin
            bad++;
            $display("FAIL reset_hold got=%b want=000000", dut_vec());
        end
        rst_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            cycle();
            if (gas_alarm === 1'b1) begin
                lat = k;
                break;
            end
        end
        total++;
        if (lat != 2 + DEB + LG) begin
            bad++;
            $display("FAIL gas_requalify latency got=%0d want=%0d (0 = timeout)", lat, 2 + DEB + LG);
        end

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 11) == 0) sw_on = ~sw_on;
            if ($urandom_range(0, 11) == 0) gases = ~gases;
            if ($urandom_range(0, 9) == 0) movimiento = ~movimiento;
            if ($urandom_range(0, 13) == 0) clave = ~clave;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
